// File: rtl/bus_sel_pkg.sv
// rtl/bus_sel_pkg.sv - shared arbiter state type and width helpers for bus_sel_arb_intc
package bus_sel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Round-robin pointer width; a single requester still needs one bit.
  function automatic int ptr_width(input int fd_num);
    return (fd_num > 1) ? $clog2(fd_num) : 1;
  endfunction

  // Hold counter runs 0..hold_max-1.
  function automatic int cnt_width(input int hold_max);
    return (hold_max > 2) ? $clog2(hold_max) : 1;
  endfunction

endpackage

// File: rtl/bus_sel_rr_arb.sv
// rtl/bus_sel_rr_arb.sv - one fifo's round-robin owner arbiter
// Optional forced release after HOLD_MAX busy cycles under BUS_SEL_ARB_TIMEOUT_EN.
module bus_sel_rr_arb
  import bus_sel_pkg::*;
#(
  parameter int FD_NUM   = 2,
  parameter int HOLD_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FD_NUM-1:0] req,
  input  logic              full,
  output logic [FD_NUM-1:0] gnt,
  output logic              busy
);

  localparam int PW = ptr_width(FD_NUM);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, win;
  logic [FD_NUM-1:0] gnt_q, gnt_d;
  logic              found;
  logic              owner_req;

`ifdef BUS_SEL_ARB_TIMEOUT_EN
  localparam int            CW       = cnt_width(HOLD_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          others_req;

  assign others_req = |(req & ~gnt_q);
`endif

  assign owner_req = |(req & gnt_q);

  // Search upward from ptr with an explicit wrap so non-power-of-two FD_NUM works.
  always_comb begin : p_search
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < FD_NUM; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= FD_NUM) idx = idx - FD_NUM;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
`ifdef BUS_SEL_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef BUS_SEL_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (!full && found) begin
          state_d = BUSY;
          gnt_d   = FD_NUM'(1) << win;
          ptr_d   = (win == PW'(FD_NUM - 1)) ? '0 : win + 1'b1;
        end
      end
      BUSY: begin
        // Release leaves one dead cycle before the next owner is picked.
        if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = '0;
`ifdef BUS_SEL_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef BUS_SEL_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          if (others_req) begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
`ifdef BUS_SEL_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
`ifdef BUS_SEL_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == BUSY);

endmodule

// File: rtl/bus_sel_arb_intc.sv
// rtl/bus_sel_arb_intc.sv - per-fifo owner arbitration between flow directors and fifos
// Hold timeout is compiled in with BUS_SEL_ARB_TIMEOUT_EN.
module bus_sel_arb_intc #(
  parameter int FD_NUM   = 2,
  parameter int FIFO_NUM = 2,
  parameter int HOLD_MAX = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FD_NUM*FIFO_NUM-1:0] fd_req,
  input  logic [FIFO_NUM-1:0]        fifo_full,
  output logic [FD_NUM*FIFO_NUM-1:0] fd_gnt,
  output logic [FIFO_NUM*FD_NUM-1:0] fifo_bus_sel,
  output logic [FIFO_NUM-1:0]        fifo_busy
);

  for (genvar y = 0; y < FIFO_NUM; y++) begin : g_fifo
    logic [FD_NUM-1:0] req_col;
    logic [FD_NUM-1:0] gnt_col;

    // fd-major request/grant vectors regrouped into one column per fifo.
    for (genvar x = 0; x < FD_NUM; x++) begin : g_fd
      assign req_col[x]                   = fd_req[x*FIFO_NUM+y];
      assign fd_gnt[x*FIFO_NUM+y]         = gnt_col[x];
      assign fifo_bus_sel[y*FD_NUM+x]     = gnt_col[x];
    end

    bus_sel_rr_arb #(
      .FD_NUM  (FD_NUM),
      .HOLD_MAX(HOLD_MAX)
    ) u_arb (
      .clk (clk),
      .rst (rst),
      .req (req_col),
      .full(fifo_full[y]),
      .gnt (gnt_col),
      .busy(fifo_busy[y])
    );
  end

endmodule

// File: tb/tb_bus_sel_arb_intc.sv
// tb/tb_bus_sel_arb_intc.sv - directed self-checking bench for bus_sel_arb_intc
// Timeout expectations follow BUS_SEL_ARB_TIMEOUT_EN.
module tb_bus_sel_arb_intc;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [3:0] fd_req_a, fd_gnt_a, sel_a;
  logic [1:0] full_a, busy_a;
  logic [2:0] fd_req_b, fd_gnt_b, sel_b;
  logic [0:0] full_b, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  bus_sel_arb_intc #(.FD_NUM(2), .FIFO_NUM(2), .HOLD_MAX(4)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .fd_req      (fd_req_a),
    .fifo_full   (full_a),
    .fd_gnt      (fd_gnt_a),
    .fifo_bus_sel(sel_a),
    .fifo_busy   (busy_a)
  );

  bus_sel_arb_intc #(.FD_NUM(3), .FIFO_NUM(1), .HOLD_MAX(4)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .fd_req      (fd_req_b),
    .fifo_full   (full_b),
    .fd_gnt      (fd_gnt_b),
    .fifo_bus_sel(sel_b),
    .fifo_busy   (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input logic [3:0] s, input logic [1:0] b);
    check({tag, "_gnt"},  32'(fd_gnt_a), 32'(g));
    check({tag, "_sel"},  32'(sel_a),    32'(s));
    check({tag, "_busy"}, 32'(busy_a),   32'(b));
  endtask

  task automatic chk_b(input string tag, input logic [2:0] g, input logic b);
    check({tag, "_gnt"},    32'(fd_gnt_b), 32'(g));
    check({tag, "_sel"},    32'(sel_b),    32'(g));
    check({tag, "_busy"},   32'(busy_b),   32'(b));
    check({tag, "_onehot"}, 32'($countones(fd_gnt_b) <= 1), 32'(1));
  endtask

  initial begin
    rst      = 1'b1;
    fd_req_a = 4'b0000;
    full_a   = 2'b00;
    fd_req_b = 3'b000;
    full_b   = 1'b0;

    repeat (2) cyc();
    chk_a("reset_a", 4'b0000, 4'b0000, 2'b00);
    chk_b("reset_b", 3'b000, 1'b0);
    rst = 1'b0;
    cyc();

    // Three requesters, one-cycle holds: order 0,1,2,0.
    fd_req_b = 3'b111;
    cyc(); chk_b("rr_g0", 3'b001, 1'b1);
    fd_req_b = 3'b110;
    cyc(); chk_b("rr_d0", 3'b000, 1'b0);
    cyc(); chk_b("rr_g1", 3'b010, 1'b1);
    fd_req_b = 3'b101;
    cyc(); chk_b("rr_d1", 3'b000, 1'b0);
    cyc(); chk_b("rr_g2", 3'b100, 1'b1);
    fd_req_b = 3'b011;
    cyc(); chk_b("rr_d2", 3'b000, 1'b0);
    cyc(); chk_b("rr_g0b", 3'b001, 1'b1);
    fd_req_b = 3'b000;
    cyc(); chk_b("rr_end", 3'b000, 1'b0);

    // fd0 and fd1 contend for fifo0; fd0 wins, holds, releases; fd1 after dead cycle.
    fd_req_a = 4'b0101;
    cyc(); chk_a("basic_c1", 4'b0001, 4'b0001, 2'b01);
    cyc(); chk_a("basic_c2", 4'b0001, 4'b0001, 2'b01);
    cyc(); chk_a("basic_c3", 4'b0001, 4'b0001, 2'b01);
    fd_req_a = 4'b0100;
    cyc(); chk_a("basic_dead", 4'b0000, 4'b0000, 2'b00);
    cyc(); chk_a("basic_fd1", 4'b0100, 4'b0010, 2'b01);
    fd_req_a = 4'b0000;
    cyc(); chk_a("basic_end", 4'b0000, 4'b0000, 2'b00);

    // Transpose: fd1->fifo0 and fd0->fifo1 concurrently.
    fd_req_a = 4'b0110;
    cyc(); chk_a("xpose", 4'b0110, 4'b0110, 2'b11);
    fd_req_a = 4'b0000;
    cyc(); chk_a("xpose_end", 4'b0000, 4'b0000, 2'b00);

    // fifo_full blocks in IDLE, not in BUSY.
    full_a   = 2'b01;
    fd_req_a = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      cyc(); chk_a("full_block", 4'b0000, 4'b0000, 2'b00);
    end
    full_a = 2'b00;
    cyc(); chk_a("full_clear", 4'b0001, 4'b0001, 2'b01);
    full_a = 2'b01;
    repeat (2) begin
      cyc(); chk_a("full_busy", 4'b0001, 4'b0001, 2'b01);
    end
    full_a   = 2'b00;
    fd_req_a = 4'b0000;
    cyc(); chk_a("full_end", 4'b0000, 4'b0000, 2'b00);

    // Asynchronous reset mid-grant; pointer back to 0 afterwards.
    fd_req_a = 4'b0001;
    cyc(); chk_a("rst_pre", 4'b0001, 4'b0001, 2'b01);
    rst = 1'b1;
    #1;
    chk_a("rst_async", 4'b0000, 4'b0000, 2'b00);
    cyc(); chk_a("rst_hold", 4'b0000, 4'b0000, 2'b00);
    rst      = 1'b0;
    fd_req_a = 4'b0101;
    #1;
    chk_a("rst_rel", 4'b0000, 4'b0000, 2'b00);
    cyc(); chk_a("rst_ptr0", 4'b0001, 4'b0001, 2'b01);
    fd_req_a = 4'b0000;
    cyc(); chk_a("rst_end", 4'b0000, 4'b0000, 2'b00);

    // Hold timeout with HOLD_MAX=4 while fd1 waits.
    fd_req_a = 4'b0001;
    cyc(); chk_a("to_c1", 4'b0001, 4'b0001, 2'b01);
    fd_req_a = 4'b0101;
    cyc(); chk_a("to_c2", 4'b0001, 4'b0001, 2'b01);
    cyc(); chk_a("to_c3", 4'b0001, 4'b0001, 2'b01);
    cyc(); chk_a("to_c4", 4'b0001, 4'b0001, 2'b01);
`ifdef BUS_SEL_ARB_TIMEOUT_EN
    cyc(); chk_a("to_dead", 4'b0000, 4'b0000, 2'b00);
    cyc(); chk_a("to_fd1", 4'b0100, 4'b0010, 2'b01);
`else
    cyc(); chk_a("to_hold5", 4'b0001, 4'b0001, 2'b01);
    cyc(); chk_a("to_hold6", 4'b0001, 4'b0001, 2'b01);
`endif
    fd_req_a = 4'b0000;
    cyc(); chk_a("to_end", 4'b0000, 4'b0000, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
